// File: rtl/gshare_btb_predictor_if.sv
// ============================================================================
// Module      : gshare_btb_predictor_if
// Description : Fetch-side prediction and commit-side update bundle for the
//               gshare/BTB predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gshare_btb_predictor_if #(
    parameter int HIST_LEN = 8
);
    logic                pred_req_i;
    logic [63:0]         pred_pc_i;
    logic                pred_valid_o;
    logic                pred_hit_o;
    logic                pred_taken_o;
    logic [63:0]         pred_target_o;
    logic [HIST_LEN-1:0] pred_ghr_o;
    logic                upd_valid_i;
    logic [63:0]         upd_pc_i;
    logic                upd_taken_i;
    logic [63:0]         upd_target_i;
    logic [HIST_LEN-1:0] upd_ghr_i;
    logic                upd_mispredict_i;

    modport master (
        output pred_req_i, pred_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_ghr_i, upd_mispredict_i,
        input  pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o
    );

    modport slave (
        input  pred_req_i, pred_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_ghr_i, upd_mispredict_i,
        output pred_valid_o, pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o
    );
endinterface

`default_nettype wire

// File: rtl/gshare_btb_predictor.sv
// ============================================================================
// Module      : gshare_btb_predictor
// Description : Tagged direct-mapped BTB plus gshare PHT with a speculative,
//               commit-repaired global history register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_btb_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int PHT_ENTRIES = 1024,
    parameter int HIST_LEN    = 8,
    parameter int CTR_BITS    = 2,
    parameter int TAG_BITS    = 16,
    parameter int USE_GHR     = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    gshare_btb_predictor_if.slave  bus
);

    localparam int                  c_bidx_w   = $clog2(BTB_ENTRIES);
    localparam int                  c_pidx_w   = $clog2(PHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] c_ctr_init = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_ctr_max  = '1;

    logic                btb_valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [63:0]         btb_target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] pht_q        [PHT_ENTRIES];

    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    logic                pred_valid_q, pred_hit_q, pred_taken_q;
    logic [63:0]         pred_target_q;
    logic [HIST_LEN-1:0] pred_ghr_q;

    logic [HIST_LEN-1:0] w_pred_hist, w_upd_hist;
    logic [c_bidx_w-1:0] w_pred_bidx, w_upd_bidx;
    logic [TAG_BITS-1:0] w_pred_tag, w_upd_tag;
    logic [c_pidx_w-1:0] w_pred_pidx, w_upd_pidx;
    logic                w_pred_hit, w_pred_taken;
    logic [63:0]         w_pred_target;
    logic [CTR_BITS-1:0] w_upd_ctr, w_upd_ctr_d;
    logic                w_unused;

    // Bimodal mode collapses both history sources to zero.
    assign w_pred_hist = (USE_GHR != 0) ? ghr_q         : '0;
    assign w_upd_hist  = (USE_GHR != 0) ? bus.upd_ghr_i : '0;

    assign w_pred_bidx = bus.pred_pc_i[2 +: c_bidx_w];
    assign w_pred_tag  = bus.pred_pc_i[2 + c_bidx_w +: TAG_BITS];
    assign w_pred_pidx = bus.pred_pc_i[2 +: c_pidx_w] ^ c_pidx_w'(w_pred_hist);

    assign w_upd_bidx  = bus.upd_pc_i[2 +: c_bidx_w];
    assign w_upd_tag   = bus.upd_pc_i[2 + c_bidx_w +: TAG_BITS];
    assign w_upd_pidx  = bus.upd_pc_i[2 +: c_pidx_w] ^ c_pidx_w'(w_upd_hist);

    assign w_pred_hit    = btb_valid_q[w_pred_bidx] && (btb_tag_q[w_pred_bidx] == w_pred_tag);
    assign w_pred_taken  = w_pred_hit && pht_q[w_pred_pidx][CTR_BITS-1];
    assign w_pred_target = w_pred_taken ? btb_target_q[w_pred_bidx] : bus.pred_pc_i + 64'd4;

    assign w_upd_ctr   = pht_q[w_upd_pidx];
    assign w_upd_ctr_d = bus.upd_taken_i
                       ? ((w_upd_ctr == c_ctr_max) ? w_upd_ctr : w_upd_ctr + 1'b1)
                       : ((w_upd_ctr == '0)        ? w_upd_ctr : w_upd_ctr - 1'b1);

    // Truncating the concatenation drops the oldest bit, which also covers HIST_LEN == 1.
    always_comb begin
        ghr_d = ghr_q;
        if (USE_GHR == 0) begin
            ghr_d = '0;
        end else if (bus.upd_valid_i && bus.upd_mispredict_i) begin
            ghr_d = HIST_LEN'({bus.upd_ghr_i, bus.upd_taken_i});
        end else if (bus.pred_req_i && w_pred_hit) begin
            ghr_d = HIST_LEN'({ghr_q, w_pred_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= c_ctr_init;
            end
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= bus.pred_req_i;
            if (bus.pred_req_i) begin
                pred_hit_q    <= w_pred_hit;
                pred_taken_q  <= w_pred_taken;
                pred_target_q <= w_pred_target;
                pred_ghr_q    <= w_pred_hist;
            end
            if (bus.upd_valid_i) begin
                pht_q[w_upd_pidx] <= w_upd_ctr_d;
                if (bus.upd_taken_i) begin
                    btb_valid_q[w_upd_bidx]  <= 1'b1;
                    btb_tag_q[w_upd_bidx]    <= w_upd_tag;
                    btb_target_q[w_upd_bidx] <= bus.upd_target_i;
                end
            end
        end
    end

    assign bus.pred_valid_o  = pred_valid_q;
    assign bus.pred_hit_o    = pred_hit_q;
    assign bus.pred_taken_o  = pred_taken_q;
    assign bus.pred_target_o = pred_target_q;
    assign bus.pred_ghr_o    = pred_ghr_q;

    assign w_unused = ^{bus.pred_pc_i, bus.upd_pc_i, bus.upd_ghr_i};

endmodule

`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
// ============================================================================
// Module      : tb_gshare_btb_predictor
// Description : Drives a gshare and a bimodal predictor with the same traffic
//               and compares both against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gshare_btb_predictor;

    localparam int HL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_btb_predictor_if #(.HIST_LEN(HL)) bus_g ();
    gshare_btb_predictor_if #(.HIST_LEN(HL)) bus_b ();

    gshare_btb_predictor #(.USE_GHR(1)) u_dut_g (.clk(clk), .rst(rst), .bus(bus_g.slave));
    gshare_btb_predictor #(.USE_GHR(0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // Reference state, index 1 = gshare instance, index 0 = bimodal instance
    bit          m_valid [2][64];
    logic [63:0] m_tag   [2][64];
    logic [63:0] m_tgt   [2][64];
    int          m_ctr   [2][1024];
    int          m_ghr   [2];

    bit          e_full  [2];
    bit          e_valid [2];
    bit          e_hit   [2];
    bit          e_taken [2];
    logic [63:0] e_tgt   [2];
    int          e_ghr   [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_cycle(int m, bit rs, bit rq, logic [63:0] pc, bit uv,
                                        logic [63:0] upc, bit ut, logic [63:0] utgt,
                                        int ughr, bit umis);
        int  hist, b, p, uh;
        bit  hit, taken;
        e_full[m] = rs || rq;
        if (rs) begin
            for (int i = 0; i < 64; i++) m_valid[m][i] = 1'b0;
            for (int i = 0; i < 1024; i++) m_ctr[m][i] = 1;
            m_ghr[m]   = 0;
            e_valid[m] = 0; e_hit[m] = 0; e_taken[m] = 0; e_tgt[m] = 64'd0; e_ghr[m] = 0;
            return;
        end
        hist       = (m == 1) ? m_ghr[m] : 0;
        hit        = 1'b0;
        taken      = 1'b0;
        e_valid[m] = rq;
        if (rq) begin
            b     = int'((pc >> 2) % 64);
            p     = int'((pc >> 2) % 1024) ^ hist;
            hit   = m_valid[m][b] && (m_tag[m][b] == (pc >> 8) % 65536);
            taken = hit && (m_ctr[m][p] >= 2);
            e_hit[m]   = hit;
            e_taken[m] = taken;
            e_tgt[m]   = taken ? m_tgt[m][b] : pc + 64'd4;
            e_ghr[m]   = hist;
        end
        if (m == 1) begin
            if (uv && umis)      m_ghr[m] = (ughr * 2 + int'(ut)) % 256;
            else if (rq && hit)  m_ghr[m] = (m_ghr[m] * 2 + int'(taken)) % 256;
        end
        if (uv) begin
            uh = (m == 1) ? ughr : 0;
            p  = int'((upc >> 2) % 1024) ^ uh;
            if (ut) m_ctr[m][p] = (m_ctr[m][p] == 3) ? 3 : m_ctr[m][p] + 1;
            else    m_ctr[m][p] = (m_ctr[m][p] == 0) ? 0 : m_ctr[m][p] - 1;
            if (ut) begin
                b = int'((upc >> 2) % 64);
                m_valid[m][b] = 1'b1;
                m_tag[m][b]   = (upc >> 8) % 65536;
                m_tgt[m][b]   = utgt;
            end
        end
    endfunction

    task automatic step(bit rs, bit rq, logic [63:0] pc, bit uv, logic [63:0] upc, bit ut,
                        logic [63:0] utgt, logic [7:0] ughr, bit umis);
        @(negedge clk);
        rst = rs;
        bus_g.pred_req_i = rq;  bus_g.pred_pc_i = pc;  bus_g.upd_valid_i = uv;
        bus_g.upd_pc_i = upc;   bus_g.upd_taken_i = ut; bus_g.upd_target_i = utgt;
        bus_g.upd_ghr_i = ughr; bus_g.upd_mispredict_i = umis;
        bus_b.pred_req_i = rq;  bus_b.pred_pc_i = pc;  bus_b.upd_valid_i = uv;
        bus_b.upd_pc_i = upc;   bus_b.upd_taken_i = ut; bus_b.upd_target_i = utgt;
        bus_b.upd_ghr_i = ughr; bus_b.upd_mispredict_i = umis;
        @(posedge clk);
        #1;
        model_cycle(1, rs, rq, pc, uv, upc, ut, utgt, int'(ughr), umis);
        model_cycle(0, rs, rq, pc, uv, upc, ut, utgt, int'(ughr), umis);
        chk("g_valid", 64'(bus_g.pred_valid_o), 64'(e_valid[1]));
        chk("b_valid", 64'(bus_b.pred_valid_o), 64'(e_valid[0]));
        if (e_full[1]) begin
            chk("g_hit",    64'(bus_g.pred_hit_o),   64'(e_hit[1]));
            chk("g_taken",  64'(bus_g.pred_taken_o), 64'(e_taken[1]));
            chk("g_target", bus_g.pred_target_o,     e_tgt[1]);
            chk("g_ghr",    64'(bus_g.pred_ghr_o),   64'(e_ghr[1]));
            chk("b_hit",    64'(bus_b.pred_hit_o),   64'(e_hit[0]));
            chk("b_taken",  64'(bus_b.pred_taken_o), 64'(e_taken[0]));
            chk("b_target", bus_b.pred_target_o,     e_tgt[0]);
            chk("b_ghr",    64'(bus_b.pred_ghr_o),   64'(e_ghr[0]));
        end
    endtask

    task automatic t_req(logic [63:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 1'b0);
    endtask

    task automatic t_upd(logic [63:0] upc, bit ut, logic [63:0] utgt, logic [7:0] ughr);
        step(1'b0, 1'b0, 64'd0, 1'b1, upc, ut, utgt, ughr, 1'b0);
    endtask

    task automatic t_rst();
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 1'b0);
    endtask

    function automatic logic [63:0] rand_pc();
        int sel = int'($urandom_range(0, 19));
        if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
        if (sel == 1) return {$urandom, $urandom};
        return 64'h1000 | (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        bus_g.pred_req_i = 1'b0; bus_g.upd_valid_i = 1'b0; bus_g.upd_mispredict_i = 1'b0;
        bus_b.pred_req_i = 1'b0; bus_b.upd_valid_i = 1'b0; bus_b.upd_mispredict_i = 1'b0;

        t_rst();
        t_rst();

        // Cold request
        t_req(64'h1000);
        chk("cold_hit",    64'(bus_g.pred_hit_o), 64'd0);
        chk("cold_target", bus_g.pred_target_o,   64'h1004);
        chk("cold_ghr",    64'(bus_g.pred_ghr_o), 64'h00);
        step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 1'b0);
        chk("valid_drop",  64'(bus_g.pred_valid_o), 64'd0);

        // Bimodal saturation walk
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h00);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h00);
        t_req(64'h1000);
        chk("bm_hit",    64'(bus_b.pred_hit_o),   64'd1);
        chk("bm_taken",  64'(bus_b.pred_taken_o), 64'd1);
        chk("bm_target", bus_b.pred_target_o,     64'h2000);
        repeat (4) t_upd(64'h1000, 1'b0, 64'd0, 8'h00);
        t_req(64'h1000);
        chk("bm_nt_hit",    64'(bus_b.pred_hit_o),   64'd1);
        chk("bm_nt_taken",  64'(bus_b.pred_taken_o), 64'd0);
        chk("bm_nt_target", bus_b.pred_target_o,     64'h1004);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h00);
        t_req(64'h1000);
        chk("bm_sat_taken", 64'(bus_b.pred_taken_o), 64'd0);

        // History chain and repair
        t_rst();
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h00);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h00);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h01);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h01);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h03);
        t_upd(64'h1000, 1'b1, 64'h2000, 8'h03);
        t_req(64'h1000);
        chk("ghr_0", 64'(bus_g.pred_ghr_o), 64'h00);
        t_req(64'h1000);
        chk("ghr_1", 64'(bus_g.pred_ghr_o), 64'h01);
        step(1'b0, 1'b1, 64'h1000, 1'b1, 64'h1000, 1'b0, 64'd0, 8'hA5, 1'b1);
        chk("ghr_3",      64'(bus_g.pred_ghr_o),   64'h03);
        chk("ghr_3_hit",  64'(bus_g.pred_hit_o),   64'd1);
        t_req(64'h1000);
        chk("ghr_repair", 64'(bus_g.pred_ghr_o),   64'h4A);

        // Aliasing on a shared BTB slot
        t_req(64'h1100);
        chk("alias_hit",    64'(bus_g.pred_hit_o), 64'd0);
        chk("alias_target", bus_g.pred_target_o,   64'h1104);
        t_upd(64'h1100, 1'b1, 64'h3000, 8'h00);
        t_req(64'h1000);
        chk("alias_evict",  64'(bus_g.pred_hit_o), 64'd0);

        // Mid-operation reset
        t_req(64'h1100);
        chk("pre_rst_hit",  64'(bus_g.pred_hit_o),   64'd1);
        t_rst();
        chk("rst_valid",    64'(bus_g.pred_valid_o), 64'd0);
        t_req(64'h1100);
        chk("post_rst_hit", 64'(bus_g.pred_hit_o),   64'd0);
        chk("post_rst_ghr", 64'(bus_g.pred_ghr_o),   64'd0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < 7),
                 rand_pc(),
                 ($urandom_range(0, 1) == 1),
                 rand_pc(),
                 ($urandom_range(0, 1) == 1),
                 {$urandom, $urandom},
                 ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
